// File: rtl/ctrl_pkg.sv
// Shared encodings for the pipelined control unit: mode, opcode, condition
// and ALU command constants plus the control bundle carried down the pipe.
package ctrl_pkg;

  localparam int CMD_W = 4;

  localparam logic [1:0] MODE_ARITH  = 2'b00;
  localparam logic [1:0] MODE_MEM    = 2'b01;
  localparam logic [1:0] MODE_BRANCH = 2'b10;

  localparam logic [3:0] OP_MOV = 4'b1101;
  localparam logic [3:0] OP_MVN = 4'b1111;
  localparam logic [3:0] OP_ADD = 4'b0100;
  localparam logic [3:0] OP_ADC = 4'b0101;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_SBC = 4'b0110;
  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_ORR = 4'b1100;
  localparam logic [3:0] OP_EOR = 4'b0001;
  localparam logic [3:0] OP_CMP = 4'b1010;
  localparam logic [3:0] OP_TST = 4'b1000;
  localparam logic [3:0] OP_LDST = 4'b0100;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

  localparam logic [CMD_W-1:0] EXE_MOV = 4'b0001;
  localparam logic [CMD_W-1:0] EXE_MVN = 4'b1001;
  localparam logic [CMD_W-1:0] EXE_ADD = 4'b0010;
  localparam logic [CMD_W-1:0] EXE_ADC = 4'b0011;
  localparam logic [CMD_W-1:0] EXE_SUB = 4'b0100;
  localparam logic [CMD_W-1:0] EXE_SBC = 4'b0101;
  localparam logic [CMD_W-1:0] EXE_AND = 4'b0110;
  localparam logic [CMD_W-1:0] EXE_ORR = 4'b0111;
  localparam logic [CMD_W-1:0] EXE_EOR = 4'b1000;

  typedef struct packed {
    logic             valid;
    logic [CMD_W-1:0] exe_cmd;
    logic             mem_read_en;
    logic             mem_write_en;
    logic             wb_en;
    logic             b;
    logic             s_out;
  } ctrl_bundle_t;

endpackage

// File: rtl/cond_check.sv
// Combinational evaluation of the ARM condition field against NZCV flags.
module cond_check
  import ctrl_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] nzcv,
  output logic       pass
);

  logic n, z, c, v;
  assign {n, z, c, v} = nzcv;

  always_comb begin
    pass = 1'b0;
    case (cond)
      COND_EQ: pass = z;
      COND_NE: pass = !z;
      COND_CS: pass = c;
      COND_CC: pass = !c;
      COND_MI: pass = n;
      COND_PL: pass = !n;
      COND_VS: pass = v;
      COND_VC: pass = !v;
      COND_HI: pass = c && !z;
      COND_LS: pass = !c || z;
      COND_GE: pass = (n == v);
      COND_LT: pass = (n != v);
      COND_GT: pass = !z && (n == v);
      COND_LE: pass = z || (n != v);
      COND_AL: pass = 1'b1;
      COND_NV: pass = 1'b0;
      default: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/pipelined_control_unit.sv
// Decode-stage control unit with NZCV status register and a PIPE_DEPTH-deep
// control pipeline. Define CTRL_SR_BYPASS_EN to forward sr_flags_in into the
// same-cycle condition check while sr_we is high.
module pipelined_control_unit
  import ctrl_pkg::*;
#(
  parameter int EXE_CMD_W  = 4,
  parameter int PIPE_DEPTH = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [3:0]           cond,
  input  logic [1:0]           mode,
  input  logic [3:0]           op_code,
  input  logic                 s_in,
  input  logic                 freeze,
  input  logic                 flush,
  input  logic                 sr_we,
  input  logic [3:0]           sr_flags_in,
  output logic                 out_valid,
  output logic [EXE_CMD_W-1:0] exe_cmd,
  output logic                 mem_read_en,
  output logic                 mem_write_en,
  output logic                 wb_en,
  output logic                 b,
  output logic                 s_out,
  output logic [3:0]           status
);

  logic [3:0]   flags_eval;
  logic         cond_pass;
  logic         defined;
  ctrl_bundle_t dec;
  ctrl_bundle_t cap;
  ctrl_bundle_t stages [PIPE_DEPTH];

`ifdef CTRL_SR_BYPASS_EN
  assign flags_eval = sr_we ? sr_flags_in : status;
`else
  assign flags_eval = status;
`endif

  cond_check u_cond_check (
    .cond (cond),
    .nzcv (flags_eval),
    .pass (cond_pass)
  );

  always_comb begin
    dec     = '0;
    defined = 1'b0;
    case (mode)
      MODE_ARITH: begin
        defined   = 1'b1;
        dec.wb_en = 1'b1;
        dec.s_out = s_in;
        case (op_code)
          OP_MOV:  dec.exe_cmd = EXE_MOV;
          OP_MVN:  dec.exe_cmd = EXE_MVN;
          OP_ADD:  dec.exe_cmd = EXE_ADD;
          OP_ADC:  dec.exe_cmd = EXE_ADC;
          OP_SUB:  dec.exe_cmd = EXE_SUB;
          OP_SBC:  dec.exe_cmd = EXE_SBC;
          OP_AND:  dec.exe_cmd = EXE_AND;
          OP_ORR:  dec.exe_cmd = EXE_ORR;
          OP_EOR:  dec.exe_cmd = EXE_EOR;
          OP_CMP: begin
            dec.exe_cmd = EXE_SUB;
            dec.wb_en   = 1'b0;
            dec.s_out   = 1'b1;
          end
          OP_TST: begin
            dec.exe_cmd = EXE_AND;
            dec.wb_en   = 1'b0;
            dec.s_out   = 1'b1;
          end
          default: defined = 1'b0;
        endcase
      end
      MODE_MEM: begin
        if (op_code == OP_LDST) begin
          defined          = 1'b1;
          dec.exe_cmd      = EXE_ADD;
          dec.mem_read_en  = s_in;
          dec.mem_write_en = !s_in;
          dec.wb_en        = s_in;
        end
      end
      MODE_BRANCH: begin
        defined = 1'b1;
        dec.b   = 1'b1;
      end
      default: defined = 1'b0;
    endcase
  end

  // Anything not issuing is captured as an all-zero bubble.
  always_comb begin
    cap = '0;
    if (in_valid && cond_pass && defined) begin
      cap       = dec;
      cap.valid = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      status <= 4'b0000;
    end else if (sr_we) begin
      status <= sr_flags_in;
    end
  end

  // Flush outranks freeze; freeze holds every stage including stage 0.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      for (int i = 0; i < PIPE_DEPTH; i++) stages[i] <= '0;
    end else if (!freeze) begin
      stages[0] <= cap;
      for (int i = 1; i < PIPE_DEPTH; i++) stages[i] <= stages[i-1];
    end
  end

  assign out_valid    = stages[PIPE_DEPTH-1].valid;
  assign exe_cmd      = EXE_CMD_W'(stages[PIPE_DEPTH-1].exe_cmd);
  assign mem_read_en  = stages[PIPE_DEPTH-1].mem_read_en;
  assign mem_write_en = stages[PIPE_DEPTH-1].mem_write_en;
  assign wb_en        = stages[PIPE_DEPTH-1].wb_en;
  assign b            = stages[PIPE_DEPTH-1].b;
  assign s_out        = stages[PIPE_DEPTH-1].s_out;

endmodule

// File: tb/tb_pipelined_control_unit.sv
// Self-checking bench for pipelined_control_unit (PIPE_DEPTH=2) with a
// queue-based reference model and literal spot checks.
module tb_pipelined_control_unit;

  localparam int W     = 4;
  localparam int DEPTH = 2;

  typedef struct packed {
    logic         v;
    logic [W-1:0] cmd;
    logic         mr;
    logic         mw;
    logic         wb;
    logic         br;
    logic         s;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst, in_valid, s_in, freeze, flush, sr_we;
  logic [3:0]   cond, op_code, sr_flags_in;
  logic [1:0]   mode;
  logic         out_valid, mem_read_en, mem_write_en, wb_en, b, s_out;
  logic [W-1:0] exe_cmd;
  logic [3:0]   status;

  int compared   = 0;
  int mismatched = 0;
  bit chk_en     = 1'b0;

  logic [3:0] cmd_tab [16];
  bit         arith_def [16];
  exp_t       q [$];
  logic [3:0] m_status = 4'b0000;

  pipelined_control_unit #(.EXE_CMD_W(W), .PIPE_DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .cond         (cond),
    .mode         (mode),
    .op_code      (op_code),
    .s_in         (s_in),
    .freeze       (freeze),
    .flush        (flush),
    .sr_we        (sr_we),
    .sr_flags_in  (sr_flags_in),
    .out_valid    (out_valid),
    .exe_cmd      (exe_cmd),
    .mem_read_en  (mem_read_en),
    .mem_write_en (mem_write_en),
    .wb_en        (wb_en),
    .b            (b),
    .s_out        (s_out),
    .status       (status)
  );

  always #5 clk = ~clk;

  function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v;
    {n, z, cy, v} = f;
    case (c)
      4'd0:    return z;
      4'd1:    return !z;
      4'd2:    return cy;
      4'd3:    return !cy;
      4'd4:    return n;
      4'd5:    return !n;
      4'd6:    return v;
      4'd7:    return !v;
      4'd8:    return cy && !z;
      4'd9:    return !cy || z;
      4'd10:   return n == v;
      4'd11:   return n != v;
      4'd12:   return !z && (n == v);
      4'd13:   return z || (n != v);
      4'd14:   return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic exp_t model_decode(input logic iv, input logic [3:0] c,
                                        input logic [1:0] md, input logic [3:0] op,
                                        input logic s, input logic [3:0] f);
    exp_t e;
    bit   def;
    e   = '0;
    def = 1'b0;
    if (md == 2'd0 && arith_def[op]) begin
      def   = 1'b1;
      e.cmd = cmd_tab[op];
      if (op == 4'd10 || op == 4'd8) begin
        e.wb = 1'b0;
        e.s  = 1'b1;
      end else begin
        e.wb = 1'b1;
        e.s  = s;
      end
    end else if (md == 2'd1 && op == 4'd4) begin
      def   = 1'b1;
      e.cmd = 4'd2;
      if (s) begin
        e.mr = 1'b1;
        e.wb = 1'b1;
      end else begin
        e.mw = 1'b1;
      end
    end else if (md == 2'd2) begin
      def  = 1'b1;
      e.br = 1'b1;
    end
    if (iv && def && cond_ok(c, f)) e.v = 1'b1;
    else e = '0;
    return e;
  endfunction

  function automatic logic [8:0] lit(input logic v, input logic [3:0] cmd, input logic mr,
                                     input logic mw, input logic wb, input logic br,
                                     input logic s);
    return {v, cmd, mr, mw, wb, br, s};
  endfunction

  function automatic logic [8:0] dut_out();
    return {out_valid, exe_cmd, mem_read_en, mem_write_en, wb_en, b, s_out};
  endfunction

  initial begin
    for (int i = 0; i < 16; i++) begin
      cmd_tab[i]   = 4'd0;
      arith_def[i] = 1'b0;
    end
    cmd_tab[13] = 4'd1; cmd_tab[15] = 4'd9; cmd_tab[4] = 4'd2;  cmd_tab[5] = 4'd3;
    cmd_tab[2]  = 4'd4; cmd_tab[6]  = 4'd5; cmd_tab[0] = 4'd6;  cmd_tab[12] = 4'd7;
    cmd_tab[1]  = 4'd8; cmd_tab[10] = 4'd4; cmd_tab[8] = 4'd6;
    foreach (arith_def[i]) arith_def[i] = (i == 13 || i == 15 || i == 4 || i == 5 ||
                                           i == 2 || i == 6 || i == 0 || i == 12 ||
                                           i == 1 || i == 10 || i == 8);
    for (int i = 0; i < DEPTH; i++) q.push_back('0);
  end

  // Reference model: a DEPTH-long queue of expected bundles plus NZCV.
  initial begin
    logic [3:0] f;
    exp_t       e;
    forever begin
      @(posedge clk);
`ifdef CTRL_SR_BYPASS_EN
      f = sr_we ? sr_flags_in : m_status;
`else
      f = m_status;
`endif
      if (rst) begin
        m_status = 4'b0000;
        for (int i = 0; i < DEPTH; i++) q[i] = '0;
      end else begin
        if (sr_we) m_status = sr_flags_in;
        if (flush) begin
          for (int i = 0; i < DEPTH; i++) q[i] = '0;
        end else if (!freeze) begin
          e = model_decode(in_valid, cond, mode, op_code, s_in, f);
          q.push_back(e);
          void'(q.pop_front());
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        compared++;
        if (dut_out() !== 9'(q[0])) begin
          mismatched++;
          $display("[TB] FAIL model_bundle t=%0t actual=%b expected=%b", $time, dut_out(), 9'(q[0]));
        end
        compared++;
        if (status !== m_status) begin
          mismatched++;
          $display("[TB] FAIL model_status t=%0t actual=%b expected=%b", $time, status, m_status);
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [8:0] actual, input logic [8:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s actual=%b expected=%b", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic iv, input logic [3:0] c, input logic [1:0] md,
                               input logic [3:0] op, input logic s, input logic fr,
                               input logic fl, input logic we, input logic [3:0] flg,
                               input logic rs);
    in_valid    = iv;
    cond        = c;
    mode        = md;
    op_code     = op;
    s_in        = s;
    freeze      = fr;
    flush       = fl;
    sr_we       = we;
    sr_flags_in = flg;
    rst         = rs;
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] c, input logic [1:0] md, input logic [3:0] op, input logic s);
    applyStimulus(1'b1, c, md, op, s, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
  endtask

  task automatic idle();
    applyStimulus(1'b0, 4'd14, 2'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
  endtask

  task automatic set_flags(input logic [3:0] flg);
    applyStimulus(1'b0, 4'd14, 2'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, flg, 1'b0);
  endtask

  initial begin
    logic [3:0] flag_set [5];
    logic [8:0] held;
    flag_set[0] = 4'b0000; flag_set[1] = 4'b0100; flag_set[2] = 4'b1001;
    flag_set[3] = 4'b0110; flag_set[4] = 4'b1010;

    applyStimulus(1'b0, 4'd0, 2'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1);
    chk_en = 1'b1;
    applyStimulus(1'b0, 4'd0, 2'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1);
    checkOutput("reset_bundle", dut_out(), 9'd0);
    checkOutput("reset_status", 9'(status), 9'd0);

    issue(4'd14, 2'd0, 4'd4, 1'b0);
    idle();
    checkOutput("add_al", dut_out(), lit(1, 4'd2, 0, 0, 1, 0, 0));

    set_flags(4'b0100);
    checkOutput("status_z", 9'(status), 9'd4);
    issue(4'd0, 2'd2, 4'd0, 1'b0);
    idle();
    checkOutput("beq_taken", dut_out(), lit(1, 4'd0, 0, 0, 0, 1, 0));
    issue(4'd1, 2'd2, 4'd0, 1'b0);
    idle();
    checkOutput("bne_bubble", dut_out(), 9'd0);

    set_flags(4'b0000);
    applyStimulus(1'b1, 4'd0, 2'd2, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0100, 1'b0);
    idle();
`ifdef CTRL_SR_BYPASS_EN
    checkOutput("beq_same_cycle", dut_out(), lit(1, 4'd0, 0, 0, 0, 1, 0));
`else
    checkOutput("beq_same_cycle", dut_out(), 9'd0);
`endif

    issue(4'd14, 2'd1, 4'd4, 1'b1);
    issue(4'd14, 2'd1, 4'd4, 1'b0);
    checkOutput("ldr", dut_out(), lit(1, 4'd2, 1, 0, 1, 0, 0));
    idle();
    checkOutput("str", dut_out(), lit(1, 4'd2, 0, 1, 0, 0, 0));

    issue(4'd14, 2'd0, 4'd10, 1'b0);
    idle();
    checkOutput("cmp", dut_out(), lit(1, 4'd4, 0, 0, 0, 0, 1));
    issue(4'd14, 2'd3, 4'd4, 1'b1);
    idle();
    checkOutput("mode11", dut_out(), 9'd0);
    issue(4'd14, 2'd0, 4'd3, 1'b0);
    idle();
    checkOutput("op0011", dut_out(), 9'd0);

    issue(4'd14, 2'd0, 4'd4, 1'b1);
    issue(4'd14, 2'd0, 4'd2, 1'b0);
    held = lit(1, 4'd2, 0, 0, 1, 0, 1);
    checkOutput("fill_head", dut_out(), held);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 4'd14, 2'd0, 4'd12, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
      checkOutput("freeze_hold", dut_out(), held);
    end
    applyStimulus(1'b1, 4'd14, 2'd0, 4'd12, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0);
    checkOutput("freeze_flush", dut_out(), 9'd0);
    idle();
    checkOutput("flush_drain", dut_out(), 9'd0);

    set_flags(4'b1111);
    issue(4'd14, 2'd0, 4'd4, 1'b0);
    applyStimulus(1'b1, 4'd14, 2'd0, 4'd4, 1'b0, 1'b1, 1'b1, 1'b1, 4'b1010, 1'b1);
    checkOutput("rst_status", 9'(status), 9'd0);
    checkOutput("rst_bundle", dut_out(), 9'd0);
    idle();
    checkOutput("rst_drain", dut_out(), 9'd0);

    foreach (flag_set[k]) begin
      set_flags(flag_set[k]);
      for (int c = 0; c < 16; c++) issue(4'(c), 2'd2, 4'd0, 1'b0);
    end
    for (int op = 0; op < 16; op++) issue(4'd14, 2'd0, 4'(op), op[0]);
    for (int op = 0; op < 16; op++) issue(4'd14, 2'd1, 4'(op), op[1]);
    idle();
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
